systolic_skew_feeder: RTL and testbench



---
 rtl/systolic_skew_feeder_pkg.sv | 19 +
 rtl/systolic_skew_feeder_delay_line.sv | 26 ++
 rtl/systolic_skew_feeder.sv | 125 ++++++++++++
 tb/tb_systolic_skew_feeder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared constants for the systolic array top-edge feeder: array opcodes
// and the feeder FSM state encoding.
package systolic_skew_feeder_pkg;

    // Array opcodes; OP_NOP is what a bubble carries.
    localparam logic [3:0] OP_NOP      = 4'd0;
    localparam logic [3:0] OP_PASS     = 4'd1;
    localparam logic [3:0] OP_GAUSS    = 4'd2;
    localparam logic [3:0] OP_EVAL     = 4'd3;
    localparam logic [3:0] OP_LOAD_KEY = 4'd4;
    localparam logic [3:0] OP_RANDOM   = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } feed_state_t;

endpackage

// File: rtl/systolic_skew_feeder_delay_line.sv
// Fixed-depth shift register; one per array column provides that column's skew.
module skew_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe;

    // Shift one stage per cycle; reset flushes every stage to the all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Top-edge feeder for the systolic array: accepts one row per cycle, tags
// burst start/finish, injects NOP bubbles when idle, skews column c by c
// cycles and blocks input while the skew pipeline drains after each burst.
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int GF_BIT       = 4,
    parameter int OP_CODE_LEN  = 4,
    parameter int NUM_PROC_COL = 3,
    parameter int ROW_CNT_W    = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_PROC_COL*GF_BIT-1:0]   in_row,
    input  logic [OP_CODE_LEN-1:0]           in_op,
    input  logic                             in_first,
    input  logic                             in_last,
    output logic [NUM_PROC_COL*GF_BIT-1:0]   out_data,
    output logic [NUM_PROC_COL*OP_CODE_LEN-1:0] out_op,
    output logic [NUM_PROC_COL-1:0]          out_start,
    output logic [NUM_PROC_COL-1:0]          out_finish,
    output logic [ROW_CNT_W-1:0]             row_cnt,
    output logic                             done,
    output logic                             err
);

    localparam int TW    = GF_BIT + OP_CODE_LEN + 2;
    localparam int CNT_W = (NUM_PROC_COL > 1) ? $clog2(NUM_PROC_COL) : 1;

    feed_state_t            state;
    logic [CNT_W-1:0]       drain_cnt;
    logic                   accept, take_row, inj_start, inj_finish;
    logic [OP_CODE_LEN-1:0] inj_op;

    // Build the stage-0 tuple: a real row only when accepted and legal in
    // the current state, otherwise a bubble (data 0, NOP, no flags).
    always_comb begin
        accept     = in_valid & in_ready;
        take_row   = accept & ((state == ST_STREAM) | ((state == ST_IDLE) & in_first));
        inj_start  = accept & (state == ST_IDLE) & in_first;
        inj_finish = take_row & in_last;
        inj_op     = take_row ? in_op : OP_CODE_LEN'(OP_NOP);
    end

    for (genvar c = 0; c < NUM_PROC_COL; c++) begin : g_col
        logic [TW-1:0] din, dout;
        assign din = {(take_row ? in_row[c*GF_BIT +: GF_BIT] : {GF_BIT{1'b0}}),
                      inj_op, inj_start, inj_finish};

        skew_delay_line #(.WIDTH(TW), .DEPTH(c+1)) u_dl (
            .clk  (clk),
            .rst  (rst),
            .din  (din),
            .dout (dout)
        );

        assign out_data[c*GF_BIT +: GF_BIT]           = dout[TW-1 -: GF_BIT];
        assign out_op[c*OP_CODE_LEN +: OP_CODE_LEN]   = dout[2 +: OP_CODE_LEN];
        assign out_start[c]                           = dout[1];
        assign out_finish[c]                          = dout[0];
    end

    // Burst FSM with registered in_ready/done; the drain counter holds
    // input off for exactly NUM_PROC_COL cycles after the last row so
    // bursts never overlap in any column.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            drain_cnt <= '0;
            row_cnt   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (in_first) begin
                            row_cnt <= ROW_CNT_W'(1);
                            if (in_last) begin
                                state     <= ST_DRAIN;
                                in_ready  <= 1'b0;
                                drain_cnt <= CNT_W'(NUM_PROC_COL - 1);
                                done      <= (NUM_PROC_COL == 1);
                            end else begin
                                state <= ST_STREAM;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (accept) begin
                        row_cnt <= row_cnt + ROW_CNT_W'(1);
                        if (in_first) err <= 1'b1;
                        if (in_last) begin
                            state     <= ST_DRAIN;
                            in_ready  <= 1'b0;
                            drain_cnt <= CNT_W'(NUM_PROC_COL - 1);
                            done      <= (NUM_PROC_COL == 1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state    <= ST_IDLE;
                        in_ready <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - CNT_W'(1);
                        done      <= (drain_cnt == CNT_W'(1));
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: a cycle-indexed history of
// injected rows plus burst bookkeeping predicts every output each cycle.
module tb_systolic_skew_feeder;

    localparam int N    = 3;
    localparam int GW   = 4;
    localparam int OW   = 4;
    localparam int RW   = 8;
    localparam int MAXC = 2048;

    logic clk, rst, in_valid, in_ready, in_first, in_last, done, err;
    logic [N*GW-1:0] in_row, out_data;
    logic [OW-1:0]   in_op;
    logic [N*OW-1:0] out_op;
    logic [N-1:0]    out_start, out_finish;
    logic [RW-1:0]   row_cnt;

    systolic_skew_feeder #(.GF_BIT(GW), .OP_CODE_LEN(OW), .NUM_PROC_COL(N), .ROW_CNT_W(RW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_row(in_row), .in_op(in_op), .in_first(in_first), .in_last(in_last),
        .out_data(out_data), .out_op(out_op), .out_start(out_start),
        .out_finish(out_finish), .row_cnt(row_cnt), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              cyc;
        logic [N*GW-1:0] data;
        logic [N*OW-1:0] op;
        logic [N-1:0]    st, fi;
        logic            done, rdy, err;
        logic [RW-1:0]   rc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference: what entered the array each cycle, and burst bookkeeping.
    logic [N*GW-1:0] h_row [MAXC];
    logic [OW-1:0]   h_op  [MAXC];
    logic            h_st  [MAXC];
    logic            h_fi  [MAXC];
    int              t = 0;
    int              last_rst = -1;
    int              block_until = -1;
    int              done_at = -1;
    bit              in_burst = 0;
    bit              m_err = 0;
    logic [RW-1:0]   m_rc = '0;
    bit              last_acc = 0;

    task automatic rst_cycle();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_row = '0; in_op = '0;
        last_rst = t; block_until = -1; done_at = -1;
        in_burst = 0; m_err = 0; m_rc = '0;
        h_row[t] = '0; h_op[t] = '0; h_st[t] = 0; h_fi[t] = 0;
        t++;
    endtask

    task automatic step(input logic v, input logic f, input logic l,
                        input logic [OW-1:0] op, input logic [N*GW-1:0] row);
        exp_t e;
        bit   rdy, acc;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = v; in_first = f; in_last = l; in_op = op; in_row = row;
        rdy = (t > block_until);
        e.cyc = t; e.rdy = rdy; e.done = (t == done_at); e.err = m_err; e.rc = m_rc;
        e.data = '0; e.op = '0; e.st = '0; e.fi = '0;
        for (int c = 0; c < N; c++) begin
            int idx;
            idx = t - 1 - c;
            if (idx > last_rst && idx >= 0) begin
                e.data[c*GW +: GW] = h_row[idx][c*GW +: GW];
                e.op[c*OW +: OW]   = h_op[idx];
                e.st[c]            = h_st[idx];
                e.fi[c]            = h_fi[idx];
            end
        end
        q.push_back(e);
        // Rules applied to this cycle's input; results are visible next cycle.
        acc = v && rdy;
        h_row[t] = '0; h_op[t] = '0; h_st[t] = 0; h_fi[t] = 0;
        if (acc) begin
            if (!in_burst) begin
                if (f) begin
                    h_row[t] = row; h_op[t] = op; h_st[t] = 1; h_fi[t] = l;
                    m_rc = 1; in_burst = 1;
                end else begin
                    m_err = 1;
                end
            end else begin
                h_row[t] = row; h_op[t] = op; h_fi[t] = l;
                m_rc = m_rc + 1'b1;
                if (f) m_err = 1;
            end
            if (in_burst && l && (h_st[t] || h_fi[t] || h_op[t] == op)) begin
                in_burst = 0;
                block_until = t + N;
                done_at = t + N;
            end
        end
        last_acc = acc;
        t++;
    endtask

    // Present a row until the reference says it was accepted (bounded).
    task automatic send(input logic f, input logic l, input logic [OW-1:0] op,
                        input logic [N*GW-1:0] row);
        int n;
        n = 0;
        do begin
            step(1'b1, f, l, op, row);
            n++;
        end while (!last_acc && n < 20);
        vectors++;
        if (!last_acc) begin
            miscompares++;
            $display("FAIL accept_timeout cycle %0d: row %h never accepted within 20 cycles", t, row);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv, input int cyc);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    // Monitor: compare DUT outputs against the queued expectation each cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("out_data",   32'(out_data),   32'(e.data), e.cyc);
            chk("out_op",     32'(out_op),     32'(e.op),   e.cyc);
            chk("out_start",  32'(out_start),  32'(e.st),   e.cyc);
            chk("out_finish", 32'(out_finish), 32'(e.fi),   e.cyc);
            chk("in_ready",   32'(in_ready),   32'(e.rdy),  e.cyc);
            chk("done",       32'(done),       32'(e.done), e.cyc);
            chk("row_cnt",    32'(row_cnt),    32'(e.rc),   e.cyc);
            chk("err",        32'(err),        32'(e.err),  e.cyc);
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_row = '0; in_op = '0;
        rst_cycle(); rst_cycle();
        idle(2);
        // three-row burst {1,2,3},{4,5,6},{7,8,9}, op 4
        send(1, 0, 4'd4, 12'h321);
        send(0, 0, 4'd4, 12'h654);
        send(0, 1, 4'd4, 12'h987);
        idle(6);
        // single-row burst {A,B,C}
        send(1, 1, 4'd2, 12'hCBA);
        idle(5);
        // two idle cycles mid-burst
        send(1, 0, 4'd3, 12'h111);
        idle(2);
        send(0, 0, 4'd3, 12'h222);
        send(0, 1, 4'd3, 12'h333);
        idle(5);
        // protocol errors: headless row in IDLE, then in_first inside a burst
        step(1, 0, 0, 4'd1, 12'hEEE);
        send(1, 0, 4'd1, 12'h456);
        send(1, 1, 4'd1, 12'h789);
        idle(6);
        // reset while draining
        send(1, 0, 4'd5, 12'hABC);
        send(0, 1, 4'd5, 12'hDEF);
        idle(1);
        rst_cycle();
        idle(5);
        // back-to-back bursts, second held valid through the drain
        send(1, 0, 4'd2, 12'h135);
        send(0, 1, 4'd2, 12'h246);
        send(1, 0, 4'd3, 12'h357);
        send(0, 1, 4'd3, 12'h468);
        idle(5);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic v, f, l;
            v = ($urandom % 10) < 7;
            f = in_burst ? (($urandom % 16) == 0) : (($urandom % 8) != 0);
            l = ($urandom % 4) == 0;
            step(v, f, l, OW'($urandom % 6), N*GW'($urandom));
        end
        idle(6);
        @(posedge clk); @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
